speed_gate_ctrl: RTL
====================

Name: speed_gate_ctrl

Overview:
Measurement-window controller for the speed path. It is the initiator side of the pulse counter's gate/clear interface: it drives gate and clr_count, waits for the counter's BCD outputs to settle, then latches cnt2/cnt1/cnt0 into held speed registers with a one-cycle valid strobe for the display and navigation logic. It supports free-running and single-shot measurement modes, and it detects overrange.

Parameters:
GATE_CYCLES, 1000, number of clk_test cycles gate is held high per measurement (>=1)
CLR_CYCLES, 1, number of cycles clr_count is asserted before each gate window (>=1)
SETTLE_CYCLES, 2, number of cycles after gate falls before the BCD digits are sampled (>=1)
CNT_W, 16, width of the internal phase counter (must hold the maximum parameter value)

Ports:
clk_test  in  1  block clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
enable  in  1  measurement enable; low aborts any measurement in progress
mode_single  in  1  1 = single-shot (needs start), 0 = free-running
start  in  1  single-cycle request; used only when mode_single=1
cnt0  in  4  counter BCD ones digit
cnt1  in  4  counter BCD tens digit
cnt2  in  4  counter BCD hundreds digit
gate  out  1  counter gate window
clr_count  out  1  counter clear
spd0  out  4  latched ones digit
spd1  out  4  latched tens digit
spd2  out  4  latched hundreds digit
spd_valid  out  1  one-cycle strobe when spd* update
ovf  out  1  sticky per-sample overrange flag, updated at each latch
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (reset=0 at an edge): state=IDLE, phase counter=0, gate=0, clr_count=1, spd0/1/2=0, spd_valid=0, ovf=0, busy=0. Reset mid-measurement takes effect the same way, with no latch.
- FSM states and outputs:
  - IDLE: clr_count=1, gate=0.
  - CLEAR: clr_count=1, gate=0.
  - GATE: gate=1, clr_count=0.
  - SETTLE: gate=0, clr_count=0.
  - LATCH: gate=0, clr_count=0, spd_valid=1 for this cycle only.
- Phase counter: cleared on every state entry; it increments each cycle in CLEAR, GATE and SETTLE.
- State transitions:
  - IDLE -> CLEAR: when enable=1 and either mode_single=0, or mode_single=1 with start=1.
  - CLEAR -> GATE: after CLR_CYCLES cycles.
  - GATE -> SETTLE: after GATE_CYCLES cycles.
  - SETTLE -> LATCH: after SETTLE_CYCLES cycles.
  - LATCH -> CLEAR: when enable=1 and mode_single=0.
  - LATCH -> IDLE: otherwise.
- Timing: gate is high for exactly GATE_CYCLES consecutive cycles. Free-running period is CLR_CYCLES+GATE_CYCLES+SETTLE_CYCLES+1 (1004 cycles with defaults). The first gate cycle begins CLR_CYCLES+1 cycles after the enabling edge.
- Latch: on entry to LATCH, the registered inputs cnt0..cnt2 are captured into spd0..spd2. spd* hold their values until the next LATCH or reset.
- Overrange: if any captured digit is >9, then spd2=spd1=spd0=9 and ovf=1. Otherwise spd*=digits and ovf=0.
- enable=0 in CLEAR, GATE or SETTLE: go to IDLE on the next edge, with gate=0. No spd_valid is issued and spd*/ovf hold their values.
- start while busy=1: ignored, not queued.
- start with enable=0: ignored.
- mode_single changed mid-measurement: takes effect only at the LATCH decision.

Test Plan:
1. reset=0 for 3 cycles, then reset=1 with enable=0 -> gate=0, clr_count=1, spd*=0, busy=0, spd_valid never asserted.
2. Free-running, enable=1, mode_single=0, counter model returns 3,7,5 (cnt2,cnt1,cnt0) -> gate high for exactly 1000 cycles, spd_valid every 1004 cycles, spd2/1/0=3/7/5, ovf=0.
3. Single-shot, start pulsed once, cnt=0/4/2 -> exactly one gate window and one spd_valid, then IDLE. A second start during GATE produces no extra measurement.
4. Overrange, cnt2=12 (4'hC), cnt1=0, cnt0=4 at latch -> spd=9/9/9, ovf=1. The next sample 1/2/3 gives spd=1/2/3, ovf=0.
5. enable dropped at GATE cycle 500 -> gate low on the next edge, state IDLE, no spd_valid, spd* keep their previous values. Re-enabling starts a full new window.
6. reset=0 asserted during SETTLE -> all outputs return to reset values on the next edge, no latch occurs.

Source files
------------

// File: rtl/speed_gate_ctrl.sv
// speed_gate_ctrl: measurement-window controller for the speed path.
// It drives the pulse counter's gate/clr_count, waits for the BCD digits to
// settle, then latches them into held speed registers with a one-cycle strobe.
//
// Ports:
//   clk_test     in   block clock, rising edge
//   reset        in   synchronous, active-low reset
//   enable       in   measurement enable; low aborts a measurement in progress
//   mode_single  in   1 = single-shot (needs start), 0 = free-running
//   start        in   single-cycle request, used only in single-shot mode
//   cnt0..cnt2   in   counter BCD digits (ones, tens, hundreds)
//   gate         out  counter gate window
//   clr_count    out  counter clear
//   spd0..spd2   out  latched speed digits
//   spd_valid    out  one-cycle strobe when spd* update
//   ovf          out  overrange flag of the most recent latch
//   busy         out  high in every state except IDLE
module speed_gate_ctrl #(
  parameter int unsigned GATE_CYCLES   = 1000,
  parameter int unsigned CLR_CYCLES    = 1,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk_test,
  input  logic       reset,
  input  logic       enable,
  input  logic       mode_single,
  input  logic       start,
  input  logic [3:0] cnt0,
  input  logic [3:0] cnt1,
  input  logic [3:0] cnt2,
  output logic       gate,
  output logic       clr_count,
  output logic [3:0] spd0,
  output logic [3:0] spd1,
  output logic [3:0] spd2,
  output logic       spd_valid,
  output logic       ovf,
  output logic       busy
);

  localparam int unsigned DIG_W = 4;
  localparam logic [DIG_W-1:0] DIG_MAX = DIG_W'(9);

  // Terminal phase values: a state of N cycles leaves when phase reaches N-1.
  localparam logic [CNT_W-1:0] CLR_LAST    = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    GATE   = 3'd2,
    SETTLE = 3'd3,
    LATCH  = 3'd4
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   phase_q;
  logic [DIG_W-1:0]   cnt0_q;
  logic [DIG_W-1:0]   cnt1_q;
  logic [DIG_W-1:0]   cnt2_q;

  logic               gate_d;
  logic               clr_d;
  logic               busy_d;
  logic               valid_d;
  logic               latch_d;
  logic               ovr_d;
  logic [DIG_W-1:0]   lat0_d;
  logic [DIG_W-1:0]   lat1_d;
  logic [DIG_W-1:0]   lat2_d;

  // Next-state decode and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    gate_d  = 1'b0;
    clr_d   = 1'b0;
    busy_d  = 1'b0;
    valid_d = 1'b0;
    latch_d = 1'b0;
    ovr_d   = 1'b0;
    lat0_d  = cnt0_q;
    lat1_d  = cnt1_q;
    lat2_d  = cnt2_q;

    case (state_q)
      IDLE: begin
        if (enable && (!mode_single || start)) state_d = CLEAR;
      end
      CLEAR: begin
        if (!enable)                   state_d = IDLE;
        else if (phase_q == CLR_LAST)  state_d = GATE;
      end
      GATE: begin
        if (!enable)                   state_d = IDLE;
        else if (phase_q == GATE_LAST) state_d = SETTLE;
      end
      SETTLE: begin
        if (!enable)                     state_d = IDLE;
        else if (phase_q == SETTLE_LAST) state_d = LATCH;
      end
      LATCH: begin
        // mode_single is only consulted here, so mid-window changes are deferred.
        if (enable && !mode_single) state_d = CLEAR;
        else                        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    gate_d  = (state_d == GATE);
    clr_d   = (state_d == IDLE) || (state_d == CLEAR);
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == LATCH);
    latch_d = (state_d == LATCH) && (state_q != LATCH);

    // Any non-BCD digit saturates the whole reading to 999.
    ovr_d = (cnt0_q > DIG_MAX) || (cnt1_q > DIG_MAX) || (cnt2_q > DIG_MAX);
    if (ovr_d) begin
      lat0_d = DIG_MAX;
      lat1_d = DIG_MAX;
      lat2_d = DIG_MAX;
    end
  end

  // State, phase counter, input sampling and registered outputs.
  always_ff @(posedge clk_test) begin
    if (!reset) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
      cnt2_q    <= '0;
      gate      <= 1'b0;
      clr_count <= 1'b1;
      busy      <= 1'b0;
      spd_valid <= 1'b0;
      spd0      <= '0;
      spd1      <= '0;
      spd2      <= '0;
      ovf       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt0_q    <= cnt0;
      cnt1_q    <= cnt1;
      cnt2_q    <= cnt2;
      gate      <= gate_d;
      clr_count <= clr_d;
      busy      <= busy_d;
      spd_valid <= valid_d;

      if (state_d != state_q) begin
        phase_q <= '0;
      end else if ((state_q == CLEAR) || (state_q == GATE) || (state_q == SETTLE)) begin
        phase_q <= phase_q + CNT_W'(1);
      end

      if (latch_d) begin
        spd0 <= lat0_d;
        spd1 <= lat1_d;
        spd2 <= lat2_d;
        ovf  <= ovr_d;
      end
    end
  end

endmodule
